// File: rtl/penalty_round_ctrl.sv
// Penalty-round sequencer: shot latch, timed keeper dive, goal/save resolve, result hold, score/round update.
// Optional automatic shot after SHOT_TIMEOUT idle cycles when PENALTY_AUTO_SHOT_EN is defined.
module penalty_round_ctrl #(
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned DIVE_CYCLES   = 32_500_000,
  parameter int unsigned RESULT_CYCLES = 65_000_000,
  parameter int unsigned SHOT_TIMEOUT  = 195_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_active,
  input  logic       player_is_keeper,
  input  logic       shot_valid,
  input  logic [2:0] shot_zone,
  input  logic       left_clicked,
  input  logic [2:0] keeper_sel,
  output logic [2:0] shot_zone_q,
  output logic [2:0] keeper_zone_q,
  output logic       result_show,
  output logic       last_goal,
  output logic       is_scored,
  output logic [3:0] round_counter,
  output logic [2:0] score
);

  localparam int unsigned TMAX_DR = (DIVE_CYCLES > RESULT_CYCLES) ? DIVE_CYCLES : RESULT_CYCLES;
  localparam int unsigned TMAX    = (TMAX_DR > SHOT_TIMEOUT) ? TMAX_DR : SHOT_TIMEOUT;
  localparam int unsigned TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_ONE       = TW'(1);
  localparam logic [TW-1:0] DIVE_LAST   = TW'(DIVE_CYCLES - 1);
  localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_CYCLES - 1);
  localparam logic [3:0]    LAST_ROUND  = 4'(ROUNDS - 1);
  localparam logic [2:0]    NO_DIVE     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SHOT,
    S_DIVE,
    S_RESOLVE,
    S_RESULT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_shot_zone;
  logic [2:0]    r_keeper_zone;
  logic          r_result_show;
  logic          r_last_goal;
  logic          r_is_scored;
  logic [3:0]    r_round;
  logic [2:0]    r_score;

  logic       w_goal;
  logic       w_point;
  logic [2:0] w_score_next;

  assign w_goal       = (r_shot_zone <= 3'd5) && (r_keeper_zone != r_shot_zone);
  assign w_point      = player_is_keeper ? ~w_goal : w_goal;
  // score saturates at 7 so extra points in long matches cannot wrap
  assign w_score_next = (w_point && (r_score != 3'd7)) ? r_score + 3'd1 : r_score;

`ifdef PENALTY_AUTO_SHOT_EN
  localparam logic [TW-1:0] SHOT_LAST = TW'(SHOT_TIMEOUT - 1);

  logic [7:0] r_lfsr;
  logic [2:0] w_auto_zone;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 8'h5A;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_auto_zone = 3'(r_lfsr % 8'd6);
`endif

  always_ff @(posedge clk) begin
    if (rst || ((r_state != S_IDLE) && !round_active)) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_shot_zone   <= '0;
      r_keeper_zone <= NO_DIVE;
      r_result_show <= 1'b0;
      r_last_goal   <= 1'b0;
      r_is_scored   <= 1'b0;
      r_round       <= '0;
      r_score       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (round_active) r_state <= S_WAIT_SHOT;
        end
        S_WAIT_SHOT: begin
          if (shot_valid) begin
            r_shot_zone   <= shot_zone;
            r_keeper_zone <= NO_DIVE;
            r_timer       <= '0;
            r_state       <= S_DIVE;
          end
`ifdef PENALTY_AUTO_SHOT_EN
          else if (r_timer == SHOT_LAST) begin
            r_shot_zone   <= w_auto_zone;
            r_keeper_zone <= NO_DIVE;
            r_timer       <= '0;
            r_state       <= S_DIVE;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
`endif
        end
        S_DIVE: begin
          if (left_clicked) begin
            r_keeper_zone <= keeper_sel;
            r_state       <= S_RESOLVE;
          end else if (r_timer == DIVE_LAST) begin
            r_state <= S_RESOLVE;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        S_RESOLVE: begin
          r_last_goal   <= w_goal;
          r_score       <= w_score_next;
          r_timer       <= '0;
          r_result_show <= 1'b1;
          r_is_scored   <= (RESULT_CYCLES == 1);
          r_state       <= S_RESULT;
        end
        S_RESULT: begin
          // is_scored is registered, so it is armed one cycle ahead of the final RESULT cycle
          if (r_timer == RESULT_LAST) begin
            r_is_scored   <= 1'b0;
            r_result_show <= 1'b0;
            r_timer       <= '0;
            if (r_round == LAST_ROUND) begin
              r_state <= S_DONE;
            end else begin
              r_round <= r_round + 4'd1;
              r_state <= S_WAIT_SHOT;
            end
          end else begin
            r_timer     <= r_timer + T_ONE;
            r_is_scored <= ((r_timer + T_ONE) == RESULT_LAST);
          end
        end
        S_DONE: begin
          r_is_scored <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign shot_zone_q   = r_shot_zone;
  assign keeper_zone_q = r_keeper_zone;
  assign result_show   = r_result_show;
  assign last_goal     = r_last_goal;
  assign is_scored     = r_is_scored;
  assign round_counter = r_round;
  assign score         = r_score;

endmodule

// File: tb/tb_penalty_round_ctrl.sv
// Scoreboard bench for penalty_round_ctrl: driver pushes per-round expectations, monitor checks each is_scored pulse.
module tb_penalty_round_ctrl;

  localparam int ROUNDS = 5;
  localparam int DIVE   = 8;
  localparam int RES    = 4;
  localparam int TO     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       round_active = 1'b0;
  logic       player_is_keeper = 1'b0;
  logic       shot_valid = 1'b0;
  logic [2:0] shot_zone = '0;
  logic       left_clicked = 1'b0;
  logic [2:0] keeper_sel = '0;
  logic [2:0] shot_zone_q;
  logic [2:0] keeper_zone_q;
  logic       result_show;
  logic       last_goal;
  logic       is_scored;
  logic [3:0] round_counter;
  logic [2:0] score;

  penalty_round_ctrl #(
    .ROUNDS(ROUNDS),
    .DIVE_CYCLES(DIVE),
    .RESULT_CYCLES(RES),
    .SHOT_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .round_active(round_active),
    .player_is_keeper(player_is_keeper),
    .shot_valid(shot_valid),
    .shot_zone(shot_zone),
    .left_clicked(left_clicked),
    .keeper_sel(keeper_sel),
    .shot_zone_q(shot_zone_q),
    .keeper_zone_q(keeper_zone_q),
    .result_show(result_show),
    .last_goal(last_goal),
    .is_scored(is_scored),
    .round_counter(round_counter),
    .score(score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int cyc;
    int rc;
    int score;
    int goal;
    int zone;
    bit zone_any;
    int kz;
  } exp_t;

  exp_t sb[$];
  int m_round;
  int m_score;
  int m_last_goal;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: goal unless the shot is wide or the keeper dived to the same zone.
  task automatic expect_round(input int s, input int zone, input bit zone_any, input bit click,
                              input int k, input int sel, output int pulse);
    exp_t e;
    int kz, goal, point;
    kz    = click ? sel : 7;
    goal  = (zone <= 5 && kz != zone) ? 1 : 0;
    point = player_is_keeper ? 1 - goal : goal;
    m_score     = (m_score + point > 7) ? 7 : m_score + point;
    m_last_goal = goal;
    pulse = s + (click ? k + 2 : DIVE + 1) + RES;
    e.cyc = pulse;
    e.rc = m_round;
    e.score = m_score;
    e.goal = goal;
    e.zone = zone;
    e.zone_any = zone_any;
    e.kz = kz;
    sb.push_back(e);
  endtask

  task automatic play(input int zone, input bit click, input int k, input int sel);
    int pulse;
    shot_valid   = 1'b1;
    shot_zone    = 3'(zone);
    left_clicked = 1'($urandom_range(0, 1));
    keeper_sel   = 3'($urandom_range(0, 5));
    expect_round(cyc, zone, 1'b0, click, k, sel, pulse);
    step(1);
    shot_valid   = 1'b0;
    left_clicked = 1'b0;
    if (click) begin
      step(k);
      left_clicked = 1'b1;
      keeper_sel   = 3'(sel);
      step(1);
      left_clicked = 1'($urandom_range(0, 1));
      keeper_sel   = 3'($urandom_range(0, 7));
      step(1);
      left_clicked = 1'b0;
    end
    while (cyc < pulse + 1) step(1);
    m_round++;
    if (m_round < ROUNDS) chk("round_counter_next", int'(round_counter), m_round);
  endtask

  task automatic start_match(input bit keeper);
    player_is_keeper = keeper;
    round_active = 1'b1;
    m_round = 0;
    m_score = 0;
    m_last_goal = 0;
    step(2);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_round_counter"}, int'(round_counter), 0);
    chk({tag, "_keeper_zone_q"}, int'(keeper_zone_q), 7);
    chk({tag, "_last_goal"}, int'(last_goal), 0);
    chk({tag, "_result_show"}, int'(result_show), 0);
    chk({tag, "_shot_zone_q"}, int'(shot_zone_q), 0);
  endtask

  task automatic done_checks(input int kz);
    step(5);
    chk("done_round_counter", int'(round_counter), ROUNDS - 1);
    chk("done_score", int'(score), m_score);
    chk("done_last_goal", int'(last_goal), m_last_goal);
    chk("done_result_show", int'(result_show), 0);
    chk("done_keeper_zone_q", int'(keeper_zone_q), kz);
    round_active = 1'b0;
    step(1);
    idle_checks("idle_after_done");
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (!rst && is_scored) begin
      if (sb.size() == 0) begin
        chk("unexpected_is_scored", int'(is_scored), 0);
      end else begin
        me = sb.pop_front();
        chk("is_scored_cycle", cyc, me.cyc);
        chk("pulse_round_counter", int'(round_counter), me.rc);
        chk("pulse_score", int'(score), me.score);
        chk("pulse_last_goal", int'(last_goal), me.goal);
        chk("pulse_keeper_zone_q", int'(keeper_zone_q), me.kz);
        chk("pulse_result_show", int'(result_show), 1);
        if (me.zone_any) chk("pulse_auto_zone_range", int'(shot_zone_q <= 3'd5), 1);
        else chk("pulse_shot_zone_q", int'(shot_zone_q), me.zone);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    int zone, sel, last_kz, pulse;
    bit click;

    rst = 1'b1;
    round_active = 1'b1;
    step(3);
    chk("reset_is_scored", int'(is_scored), 0);
    idle_checks("reset");
    rst = 1'b0;
    step(1);

    // directed match: keeper saves in rounds 0, 2, 4; round 1 is a dive timeout
    player_is_keeper = 1'b1;
    m_round = 0;
    m_score = 0;
    m_last_goal = 0;
    play(2, 1'b1, 3, 2);
    play(4, 1'b0, 0, 0);
    play(0, 1'b1, 0, 0);
    play(5, 1'b1, 7, 1);
    play(3, 1'b1, 5, 3);
    done_checks(3);

    // abort during DIVE after a scored round
    start_match(1'b0);
    play(1, 1'b0, 0, 0);
    shot_valid = 1'b1;
    shot_zone  = 3'd3;
    step(1);
    shot_valid = 1'b0;
    step(3);
    round_active = 1'b0;
    step(1);
    idle_checks("abort");
    step(20);

`ifdef PENALTY_AUTO_SHOT_EN
    start_match(1'b0);
    play(2, 1'b0, 0, 0);
    expect_round(cyc + TO - 1, 0, 1'b1, 1'b0, 0, 0, pulse);
    while (cyc < pulse + 1) step(1);
    m_round++;
    step(TO - 1);
    play(6, 1'b0, 0, 0);
    round_active = 1'b0;
    step(1);
    idle_checks("auto_abort");
`else
    start_match(1'b1);
    step(40);
    play(5, 1'b1, 2, 5);
    round_active = 1'b0;
    step(1);
    idle_checks("long_wait_abort");
`endif

    for (int m = 0; m < 8; m++) begin
      start_match(1'($urandom_range(0, 1)));
      last_kz = 7;
      for (int r = 0; r < ROUNDS; r++) begin
        step($urandom_range(0, 3));
        zone  = $urandom_range(0, 7);
        click = ($urandom_range(0, 3) != 0);
        sel   = (zone <= 5 && $urandom_range(0, 1) == 1) ? zone : $urandom_range(0, 5);
        last_kz = click ? sel : 7;
        play(zone, click, $urandom_range(0, DIVE - 1), sel);
      end
      done_checks(last_kz);
    end

    step(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/penalty_round_ctrl.md
Name: penalty_round_ctrl

Overview:
- Sequences the penalty rounds of one match.
- Per round it:
  - latches the shot zone;
  - opens a timed keeper-dive window;
  - resolves goal or save;
  - holds the result for display;
  - updates score and round counter.
- Produces the is_scored / round_counter / score information that the next-state controller uses to leave KEEPER/SHOOTER for WINNER/LOOSER.
- Sits between the mouse/shot-generation logic and the game state controller.

Parameters:
- ROUNDS, 5, rounds per match (1..15).
- DIVE_CYCLES, 32_500_000, length of the keeper-dive window in clk cycles.
- RESULT_CYCLES, 65_000_000, clk cycles the goal/save result is held before the round closes.
- SHOT_TIMEOUT, 195_000_000, clk cycles of WAIT_SHOT before an automatic shot (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- round_active  in  1  high while game state is KEEPER or SHOOTER
- player_is_keeper  in  1  1: local player scores on saves; 0: on goals
- shot_valid  in  1  one-cycle pulse, shot_zone valid
- shot_zone  in  3  target zone 0..5; 6..7 = wide
- left_clicked  in  1  one-cycle pulse, keeper dive request
- keeper_sel  in  3  zone under cursor at click, 0..5
- shot_zone_q  out  3  latched shot zone
- keeper_zone_q  out  3  latched dive zone; 7 = no dive
- result_show  out  1  high during RESULT
- last_goal  out  1  result of last resolved round (1 = goal)
- is_scored  out  1  one-cycle pulse at round close
- round_counter  out  4  0-based index of current/just-closed round
- score  out  3  local player points, saturates at 7

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. On rst:
  - state = IDLE;
  - all outputs 0, except keeper_zone_q = 7;
  - timers cleared.
- States: IDLE, WAIT_SHOT, DIVE, RESOLVE, RESULT, DONE.
- IDLE:
  - counters and latches held cleared (round_counter = 0, score = 0, keeper_zone_q = 7, last_goal = 0);
  - round_active = 1 → WAIT_SHOT next cycle.
- WAIT_SHOT:
  - on shot_valid: shot_zone_q <= shot_zone; keeper_zone_q <= 7; timer <= 0; → DIVE;
  - left_clicked is ignored in this state, including when coincident with shot_valid.
- DIVE:
  - timer increments every cycle;
  - the first left_clicked latches keeper_zone_q <= keeper_sel and → RESOLVE next cycle;
  - timer == DIVE_CYCLES-1 with no click → RESOLVE with keeper_zone_q = 7.
- RESOLVE (exactly 1 cycle):
  - goal = (shot_zone_q <= 5) && (keeper_zone_q != shot_zone_q);
  - last_goal <= goal;
  - point = player_is_keeper ? !goal : goal;
  - score <= score + point, saturating at 7;
  - timer <= 0; → RESULT.
- RESULT:
  - result_show = 1 while in this state;
  - at timer == RESULT_CYCLES-1, is_scored = 1 for that single cycle, with round_counter still showing the closing round index and score already including that round;
  - next cycle: if round_counter == ROUNDS-1 → DONE, else round_counter++ and → WAIT_SHOT.
- DONE:
  - all outputs frozen, is_scored = 0;
  - round_active = 0 → IDLE.
- round_active deasserted in any state other than IDLE → IDLE next cycle; no is_scored pulse; values cleared.
- Latency:
  - click to RESOLVE: 1 cycle;
  - RESOLVE to score visible: registered, 1 cycle;
  - is_scored: exactly one pulse per round, never two in consecutive cycles.
- Widths:
  - timer is wide enough for max(DIVE_CYCLES, RESULT_CYCLES, SHOT_TIMEOUT);
  - round_counter never exceeds ROUNDS-1.

Optional Feature:
- Macro: PENALTY_AUTO_SHOT_EN.
- Defined:
  - an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h5A on rst) advances every cycle;
  - in WAIT_SHOT, a shot counter runs;
  - if no shot_valid within SHOT_TIMEOUT cycles, shot_zone_q <= lfsr % 6 and → DIVE, exactly as if shot_valid had arrived;
  - an external shot_valid takes priority in the same cycle;
  - the counter clears on leaving WAIT_SHOT.
- Undefined: WAIT_SHOT waits indefinitely; no LFSR logic is synthesized.

Test Plan (ROUNDS=5, DIVE_CYCLES=8, RESULT_CYCLES=4, SHOT_TIMEOUT=16):
- Reset check:
  - stimulus: rst held, round_active=1;
  - required: all outputs 0, keeper_zone_q=7, no is_scored;
  - after release: WAIT_SHOT.
- Save counted for keeper:
  - stimulus: player_is_keeper=1; shot_valid with zone 2; click in DIVE cycle 3 with keeper_sel=2;
  - required: last_goal=0, score=1;
  - is_scored pulses 4 cycles after RESOLVE with round_counter=0;
  - then round_counter=1.
- Dive timeout:
  - stimulus: shot zone 4, no click;
  - required: RESOLVE after 8 DIVE cycles, keeper_zone_q=7, last_goal=1, score unchanged.
- Full match:
  - stimulus: 5 rounds with saves in rounds 0, 2, 4;
  - required: final is_scored pulse with round_counter=4, score=3;
  - DONE holds values; dropping round_active → IDLE, score=0.
- Abort mid-round:
  - stimulus: round_active falls during DIVE;
  - required: no is_scored, IDLE next cycle, counters cleared.
- With PENALTY_AUTO_SHOT_EN:
  - stimulus: no shot_valid for 16 cycles;
  - required: DIVE entered with shot_zone_q in 0..5;
  - shot_valid coincident with the timeout cycle wins.
